// File: rtl/div_seq.sv
// Sequential non-restoring divider: one quotient bit per cycle, signed/unsigned,
// with cancel, done pulse and divide-by-zero flag. Option: DIV_ZERO_FASTPATH_EN.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [WIDTH:0]   pr;       // signed partial remainder
  logic [WIDTH-1:0] acc;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd_raw;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg, zdiv;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   pr_sh, pr_nx;
  logic [WIDTH-1:0] r_mag, q_fix, r_fix;

  always_comb begin
    a_neg = sign & dividend[WIDTH-1];
    b_neg = sign & divisor[WIDTH-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor  : divisor;
  end

  always_comb begin
    pr_sh = {pr[WIDTH-1:0], acc[WIDTH-1]};
    pr_nx = pr[WIDTH] ? pr_sh + {1'b0, dvs} : pr_sh - {1'b0, dvs};
  end

  // The final remainder lies in [-D, D), so the restore fits in WIDTH bits.
  always_comb begin
    r_mag = pr[WIDTH] ? pr[WIDTH-1:0] + dvs : pr[WIDTH-1:0];
    q_fix = q_neg ? -acc   : acc;
    r_fix = r_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pr      <= '0;
      acc     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      zdiv    <= 1'b0;
      q       <= '0;
      r       <= '0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            pr      <= '0;
            acc     <= a_mag;
            dvs     <= b_mag;
            dvd_raw <= dividend;
            cnt     <= '0;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            zdiv    <= (divisor == '0);
            busy    <= 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
            state   <= (divisor == '0) ? FIX : ITER;
`else
            state   <= ITER;
`endif
          end
        end
        ITER: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            pr  <= pr_nx;
            acc <= {acc[WIDTH-2:0], ~pr_nx[WIDTH]};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            q    <= zdiv ? '1 : q_fix;
            r    <= zdiv ? dvd_raw : r_fix;
            dz   <= zdiv;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq (WIDTH=32 and WIDTH=8 instances).
module tb_div_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, sign, cancel;
  logic [31:0] dividend, divisor, q, r;
  logic        dz, busy, done;

  logic        start8, sign8, cancel8;
  logic [7:0]  dividend8, divisor8, q8, r8;
  logic        dz8, busy8, done8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  div_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .sign(sign), .cancel(cancel),
    .dividend(dividend), .divisor(divisor), .q(q), .r(r), .dz(dz),
    .busy(busy), .done(done));

  div_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .sign(sign8), .cancel(cancel8),
    .dividend(dividend8), .divisor(divisor8), .q(q8), .r(r8), .dz(dz8),
    .busy(busy8), .done(done8));

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, eq, er;
    logic        edz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts one op, returns edges from accept to done and busy-high samples.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcnt);
    sign = s; dividend = a; divisor = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0;
    if (busy) bcnt++;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL run32_timeout: got no done expected done within 100");
    end
    chk("done_busy_overlap", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat, bcnt, ndone, last, first;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, -32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0};
    vecs[2]  = '{1'b1, 32'd100,        -32'sd7,        -32'sd14,       32'd2,          1'b0};
    vecs[3]  = '{1'b1, -32'sd100,      -32'sd7,        32'd14,         -32'sd2,        1'b0};
    vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5]  = '{1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1};
    vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    vecs[10] = '{1'b1, -32'sd7,        32'd2,          -32'sd3,        -32'sd1,        1'b0};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0};

    reset = 1'b0; start = 0; sign = 0; cancel = 0; dividend = 0; divisor = 0;
    start8 = 0; sign8 = 0; cancel8 = 0; dividend8 = 0; divisor8 = 0;
    repeat (3) tick();
    chk("reset_q", {32'd0, q}, 64'd0);
    chk("reset_r", {32'd0, r}, 64'd0);
    chk("reset_flags", {61'd0, dz, busy, done}, 64'd0);
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run32(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_q", i), {32'd0, q}, {32'd0, vecs[i].eq});
      chk($sformatf("v%0d_r", i), {32'd0, r}, {32'd0, vecs[i].er});
      chk($sformatf("v%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].edz});
      chk($sformatf("v%0d_lat", i), 64'(lat), vecs[i].edz ? 64'(DZ_LAT) : 64'd33);
      chk($sformatf("v%0d_busy", i), 64'(bcnt), vecs[i].edz ? 64'(DZ_LAT) : 64'd33);
      tick();
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    // Restart request mid-operation must be ignored.
    sign = 0; dividend = 100; divisor = 7; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    dividend = 50; divisor = 5; start = 1;
    tick();
    start = 0;
    lat = 6;
    for (int i = 0; i < 60 && !done; i++) begin tick(); lat++; end
    chk("ignore_q", {32'd0, q}, 64'd14);
    chk("ignore_r", {32'd0, r}, 64'd2);
    chk("ignore_lat", 64'(lat), 64'd33);
    tick();

    // Cancel at iteration 10: prior result (1000/10) must hold.
    run32(1'b0, 32'd1000, 32'd10, lat, bcnt);
    tick();
    dividend = 100; divisor = 7; start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    cancel = 1;
    tick();
    cancel = 0;
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done || busy) ndone++; end
    chk("cancel_no_done", 64'(ndone), 64'd0);
    chk("cancel_q_hold", {32'd0, q}, 64'd100);
    chk("cancel_r_hold", {32'd0, r}, 64'd0);

    // Same-cycle start + cancel in IDLE.
    dividend = 9; divisor = 3; start = 1; cancel = 1;
    tick();
    start = 0; cancel = 0;
    chk("sc_busy", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (done) ndone++; end
    chk("sc_no_done", 64'(ndone), 64'd0);

    // Reset at iteration 20.
    dividend = 100; divisor = 7; start = 1;
    tick();
    start = 0;
    repeat (20) tick();
    reset = 0;
    #1;
    chk("mid_reset_q", {32'd0, q}, 64'd0);
    chk("mid_reset_r", {32'd0, r}, 64'd0);
    chk("mid_reset_flags", {61'd0, dz, busy, done}, 64'd0);
    tick();
    reset = 1;
    tick();
    run32(1'b0, 32'd1, 32'd1, lat, bcnt);
    chk("post_reset_q", {32'd0, q}, 64'd1);
    chk("post_reset_r", {32'd0, r}, 64'd0);
    tick();

    // Start held high: ops repeat every 34 cycles.
    sign = 0; dividend = 100; divisor = 7; start = 1;
    ndone = 0; last = -1; first = 1;
    for (int c = 0; c < 200 && ndone < 3; c++) begin
      tick();
      if (done) begin
        if (!first) chk("b2b_period", 64'(c - last), 64'd34);
        first = 0; last = c; ndone++;
        chk("b2b_q", {32'd0, q}, 64'd14);
        if (ndone == 3) start = 0;
        tick(); c++;
        chk("b2b_single_done", {63'd0, done}, 64'd0);
      end
    end
    start = 0;
    chk("b2b_count", 64'(ndone), 64'd3);
    repeat (3) tick();

    // WIDTH=8 instance: -128 / 3.
    sign8 = 1; dividend8 = 8'h80; divisor8 = 8'd3; start8 = 1;
    tick();
    start8 = 0;
    lat = 0;
    for (int i = 0; i < 30 && !done8; i++) begin tick(); lat++; end
    chk("w8_q", {56'd0, q8}, 64'hD6);
    chk("w8_r", {56'd0, r8}, 64'hFE);
    chk("w8_lat", 64'(lat), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
